ball_controller: RTL
====================

// Module: ball_controller
// PURPOSE
//  Owns the ball: registered position/velocity, serve/play/lost sequencing, per-pixel ball mask.
//  Pixel side: flags ball pixels and their four edge rows/columns for the current beam position.
//  Collision side: latches which sides touched a solid pixel (hit_in) during the frame.
//  Frame side: bounces the ball on frame_end and advances it.
//  Sits beside the paddle/brick painters; feeds the colour mux and the sound/score logic.
// PARAMETERS
//  X_WIDTH      10         hpos / ball x width
//  Y_WIDTH      9          vpos / ball y width
//  RADIUS       2          ball half-size in pixels; corners cut (see BEHAVIOUR); 1..7
//  SCREEN_H     480        ball is lost when y+RADIUS >= SCREEN_H
//  SERVE_Y      440        ball centre y while in SERVE
//  SPEED_INIT   1          |vx|,|vy| after reset and after each loss
//  SPEED_MAX    4          upper clamp for speed_up
//  BALL_COLOR   6'b001100  BBGGRR
// PORTS
//  clk             in   1        pixel clock
//  rst_n           in   1        synchronous reset, active low
//  hpos            in   X_WIDTH  beam x
//  vpos            in   Y_WIDTH  beam y
//  frame_end       in   1        1-cycle strobe, once per frame, during vertical blank
//  hit_in          in   1        a solid object (wall/brick/paddle) is drawn at hpos/vpos this cycle
//  paddle_x        in   X_WIDTH  paddle centre; ball x follows it in SERVE
//  launch          in   1        level/pulse; leaves SERVE
//  speed_up        in   1        1-cycle strobe; speed +1, saturating at SPEED_MAX
//  in_ball         out  1        beam on a ball pixel (combinational from registered state)
//  in_ball_top     out  1        beam on the top edge row of the ball
//  in_ball_bottom  out  1        beam on the bottom edge row
//  in_ball_left    out  1        beam on the left edge column
//  in_ball_right   out  1        beam on the right edge column
//  color           out  6        BALL_COLOR
//  ball_x          out  X_WIDTH  registered centre x
//  ball_y          out  Y_WIDTH  registered centre y
//  bounce          out  1        1-cycle pulse: at least one axis flipped at this frame_end
//  ball_lost       out  1        1-cycle pulse: ball left bottom of screen
// BEHAVIOUR
//  Clocking: single clock clk; rst_n is synchronous and active low. All state updates on rising clk.
//  Reset values: state=SERVE; x=paddle_x; y=SERVE_Y; vx=+SPEED_INIT; vy=-SPEED_INIT.
//    Also: all side latches 0; bounce=0; ball_lost=0.
//  Mask geometry:
//    dx=hpos-x and dy=vpos-y are computed signed at width+1 bits; no wrap at screen edge x<RADIUS.
//    in_ball = (|dx|<=R && |dy|<=R-1) || (|dx|<=R-1 && |dy|<=R).
//    Edges:
//      top    = dy==-R, |dx|<=R-1
//      bottom = dy==+R, |dx|<=R-1
//      left   = dx==-R, |dy|<=R-1
//      right  = dx==+R, |dy|<=R-1
//    RADIUS=2 reproduces the existing 5x5 corner-cut ball.
//  Side latches (PLAY only): each cycle, hit_in && in_ball_<side> sets lat_<side>.
//    Latches clear on the cycle after frame_end.
//  States:
//    SERVE: x<=paddle_x each cycle; y held at SERVE_Y. launch -> PLAY with vx=+spd, vy=-spd.
//    PLAY: on frame_end:
//      vy flips to +|vy| if lat_top and !lat_bottom.
//      vy flips to -|vy| if lat_bottom and !lat_top.
//      vx is handled the same way using left/right.
//      Both opposite sides latched -> that axis is unchanged.
//      Then x+=vx_new, y+=vy_new, all in the same cycle.
//      bounce=1 for that cycle if any axis changed.
//      If y_new+R >= SCREEN_H -> LOST.
//    LOST: ball_lost=1 for exactly one cycle.
//      Velocity resets to SPEED_INIT magnitudes (+x,-y); the next state is SERVE.
//  Latency: the new position is visible from the cycle after frame_end. Pixel outputs have zero latency.
//  speed_up: increments spd, saturating at SPEED_MAX.
//    Magnitudes of vx/vy take the new spd at the next frame_end; signs are preserved.
//  Arithmetic: vx/vy are signed 4-bit. Position add uses a signed extension of x/y.
//    If the top result goes below R, clamp y to R and force vy positive; left/right clamp likewise.
//  frame_end in SERVE or LOST: no motion; latches stay clear.
//  launch together with frame_end: the state changes to PLAY, and that frame_end is ignored.
//  Reset mid-PLAY: the next cycle is SERVE with reset values; no ball_lost pulse.
// STRUCTURE
//  Shared package breakout_pkg:
//    ball_state_t enum {SERVE, PLAY, LOST}
//    COLOR_W=6
//    screen constants (SCREEN_W, SCREEN_H)
//  Sub-module ball_mask (pure combinational):
//    inputs x, y, hpos, vpos; parameter RADIUS
//    outputs in_ball plus the four edge flags
//  ball_mask is reused by the previews/lives display.
//  Controller holds the FSM, velocity and latches.
// TESTING
//  T1 Mask:
//    R=2, x=100, y=50.
//    Sweep hpos 96..104 and vpos 46..54.
//    Exactly 21 in_ball pixels. (98,48) off; (99,48) top; (102,50) right.
//  T2 Serve/launch:
//    After reset, drive paddle_x=200 -> ball_x=200, ball_y=440.
//    Pulse launch then frame_end -> ball_x=201, ball_y=439.
//  T3 Top bounce:
//    In PLAY, hold hit_in=1 only while in_ball_top.
//    At frame_end: vy becomes +1, bounce=1 for 1 cycle, y increases by 1.
//  T4 Opposing hits:
//    Hit both left and right in one frame -> vx unchanged, bounce=0.
//    Hit top+left -> both axes flip.
//  T5 Loss:
//    y=477, vy=+1 at frame_end -> ball_lost=1 for 1 cycle.
//    Then SERVE at y=440, vx=+1, vy=-1.
//  T6 Reset mid-PLAY and speed_up:
//    4x speed_up -> |v|=4 (saturated) after the next frame_end.
//    rst_n=0 for 1 cycle -> SERVE, speed=1, no ball_lost pulse.

Source files
------------

// File: rtl/breakout_pkg.sv
// breakout_pkg: shared types and screen constants for the breakout painters
package breakout_pkg;
  typedef enum logic [1:0] {SERVE, PLAY, LOST} ball_state_t;
  localparam int COLOR_W  = 6;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
endpackage

// File: rtl/ball_mask.sv
// ball_mask: corner-cut square ball mask plus its four edge rows/columns
module ball_mask #(
  parameter int X_WIDTH = 10,
  parameter int Y_WIDTH = 9,
  parameter int RADIUS  = 2
) (
  input  logic [X_WIDTH-1:0] x,
  input  logic [Y_WIDTH-1:0] y,
  input  logic [X_WIDTH-1:0] hpos,
  input  logic [Y_WIDTH-1:0] vpos,
  output logic               in_ball,
  output logic               in_ball_top,
  output logic               in_ball_bottom,
  output logic               in_ball_left,
  output logic               in_ball_right
);
  int dx, dy, ax, ay;
  // one extra bit keeps beam-left-of-ball negative instead of wrapping
  always_comb begin
    dx = int'($signed({1'b0, hpos})) - int'($signed({1'b0, x}));
    dy = int'($signed({1'b0, vpos})) - int'($signed({1'b0, y}));
    ax = dx < 0 ? -dx : dx;
    ay = dy < 0 ? -dy : dy;
    in_ball        = (ax <= RADIUS && ay <= RADIUS - 1) || (ax <= RADIUS - 1 && ay <= RADIUS);
    in_ball_top    = dy == -RADIUS && ax <= RADIUS - 1;
    in_ball_bottom = dy == RADIUS && ax <= RADIUS - 1;
    in_ball_left   = dx == -RADIUS && ay <= RADIUS - 1;
    in_ball_right  = dx == RADIUS && ay <= RADIUS - 1;
  end
endmodule

// File: rtl/ball_controller.sv
// ball_controller: ball position/velocity, serve/play/lost sequencing and pixel mask
module ball_controller #(
  parameter int               X_WIDTH    = 10,
  parameter int               Y_WIDTH    = 9,
  parameter int               RADIUS     = 2,
  parameter int               SCREEN_H   = 480,
  parameter int               SERVE_Y    = 440,
  parameter int               SPEED_INIT = 1,
  parameter int               SPEED_MAX  = 4,
  parameter logic [5:0]       BALL_COLOR = 6'b001100
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [X_WIDTH-1:0]               hpos,
  input  logic [Y_WIDTH-1:0]               vpos,
  input  logic                             frame_end,
  input  logic                             hit_in,
  input  logic [X_WIDTH-1:0]               paddle_x,
  input  logic                             launch,
  input  logic                             speed_up,
  output logic                             in_ball,
  output logic                             in_ball_top,
  output logic                             in_ball_bottom,
  output logic                             in_ball_left,
  output logic                             in_ball_right,
  output logic [breakout_pkg::COLOR_W-1:0] color,
  output logic [X_WIDTH-1:0]               ball_x,
  output logic [Y_WIDTH-1:0]               ball_y,
  output logic                             bounce,
  output logic                             ball_lost
);
  import breakout_pkg::*;
  localparam int X_MAX = SCREEN_W - 1 - RADIUS;
  localparam logic signed [3:0] V_INIT = 4'(SPEED_INIT);
  ball_state_t        state_q, state_d;
  logic [X_WIDTH-1:0] x_q, x_d;
  logic [Y_WIDTH-1:0] y_q, y_d;
  logic signed [3:0]  vx_q, vx_d, vy_q, vy_d;
  logic [2:0]         spd_q, spd_d;
  logic [3:0]         lat_q, lat_d;
  logic               bounce_q, bounce_d, lost_q, lost_d;
  logic signed [3:0]  sv, vxn, vyn, vxf, vyf;
  logic               xlo, xhi, ylo, flip, gone;
  int                 xi, yi, xf, yf;

  ball_mask #(.X_WIDTH(X_WIDTH), .Y_WIDTH(Y_WIDTH), .RADIUS(RADIUS)) u_mask (
    .x(x_q), .y(y_q), .hpos(hpos), .vpos(vpos),
    .in_ball(in_ball), .in_ball_top(in_ball_top), .in_ball_bottom(in_ball_bottom),
    .in_ball_left(in_ball_left), .in_ball_right(in_ball_right)
  );

  // lat_q = {top, bottom, left, right}; opposite sides together cancel
  always_comb begin
    sv   = $signed({1'b0, spd_q});
    vxn  = (lat_q[1] && !lat_q[0]) ? sv : (lat_q[0] && !lat_q[1]) ? -sv : vx_q[3] ? -sv : sv;
    vyn  = (lat_q[3] && !lat_q[2]) ? sv : (lat_q[2] && !lat_q[3]) ? -sv : vy_q[3] ? -sv : sv;
    xi   = int'($signed({1'b0, x_q})) + int'(vxn);
    yi   = int'($signed({1'b0, y_q})) + int'(vyn);
    xlo  = xi < RADIUS;
    xhi  = xi > X_MAX;
    ylo  = yi < RADIUS;
    xf   = xlo ? RADIUS : xhi ? X_MAX : xi;
    yf   = ylo ? RADIUS : yi;
    vxf  = xlo ? sv : xhi ? -sv : vxn;
    vyf  = ylo ? sv : vyn;
    flip = (vxf[3] ^ vx_q[3]) | (vyf[3] ^ vy_q[3]);
    gone = yf + RADIUS >= SCREEN_H;
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    spd_d    = (speed_up && spd_q < 3'(SPEED_MAX)) ? spd_q + 3'd1 : spd_q;
    lat_d    = (state_q == PLAY && !frame_end) ?
               lat_q | ({in_ball_top, in_ball_bottom, in_ball_left, in_ball_right} & {4{hit_in}}) : 4'b0;
    bounce_d = 1'b0;
    lost_d   = 1'b0;
    case (state_q)
      SERVE: begin
        x_d = paddle_x;
        y_d = Y_WIDTH'(SERVE_Y);
        if (launch) begin
          state_d = PLAY;
          vx_d    = sv;
          vy_d    = -sv;
        end
      end
      PLAY: if (frame_end) begin
        x_d      = X_WIDTH'(xf);
        y_d      = Y_WIDTH'(yf);
        vx_d     = vxf;
        vy_d     = vyf;
        bounce_d = flip;
        lost_d   = gone;
        state_d  = gone ? LOST : PLAY;
      end
      default: begin
        state_d = SERVE;
        x_d     = paddle_x;
        y_d     = Y_WIDTH'(SERVE_Y);
        vx_d    = V_INIT;
        vy_d    = -V_INIT;
        spd_d   = 3'(SPEED_INIT);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= SERVE;
      x_q      <= paddle_x;
      y_q      <= Y_WIDTH'(SERVE_Y);
      vx_q     <= V_INIT;
      vy_q     <= -V_INIT;
      spd_q    <= 3'(SPEED_INIT);
      lat_q    <= 4'b0;
      bounce_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      spd_q    <= spd_d;
      lat_q    <= lat_d;
      bounce_q <= bounce_d;
      lost_q   <= lost_d;
    end
  end

  assign color     = BALL_COLOR;
  assign ball_x    = x_q;
  assign ball_y    = y_q;
  assign bounce    = bounce_q;
  assign ball_lost = lost_q;
endmodule
